// File: rtl/sync_filter_if.sv
// sync_filter_if: bundles the per-channel signals of sync_filter.
//   async_in    : asynchronous level inputs, one per channel
//   filt_bypass : per-channel filter bypass (synchronous to clk)
//   sync_out    : raw synchronised level (last synchroniser stage)
//   filt_out    : debounced, stable level
//   rise / fall : one-cycle pulses on 0->1 / 1->0 changes of filt_out
//   any_edge    : OR of all rise/fall pulses, coincident with them
// master = the driving side (control logic / bench), slave = sync_filter.
interface sync_filter_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] async_in;
  logic [WIDTH-1:0] filt_bypass;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] filt_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             any_edge;

  modport master (
    output async_in, filt_bypass,
    input  sync_out, filt_out, rise, fall, any_edge
  );

  modport slave (
    input  async_in, filt_bypass,
    output sync_out, filt_out, rise, fall, any_edge
  );
endinterface

// File: rtl/sync_filter.sv
// sync_filter: multi-channel CDC front end. Each channel passes through a
// NUM_FFS-deep flip-flop synchroniser, a debounce filter that needs
// FILT_CYCLES consecutive differing samples to accept a new level, and a
// registered edge detector.
// Ports:
//   clk : sole clock, posedge
//   rst : asynchronous active-high reset
//   bus : sync_filter_if slave modport (async_in, filt_bypass in;
//         sync_out, filt_out, rise, fall, any_edge out)
module sync_filter #(
  parameter int               WIDTH       = 4,
  parameter int               NUM_FFS     = 2,
  parameter int               FILT_CYCLES = 4,
  parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
  input  logic        clk,
  input  logic        rst,
  sync_filter_if.slave bus
);

  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYCLES - 1);

  // Synchroniser chain: pure flops, no logic between stages.
  logic [WIDTH-1:0] stage_reg [NUM_FFS];
  logic [WIDTH-1:0] sync_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg[0] <= RST_VAL;
    end else begin
      stage_reg[0] <= bus.async_in;
    end
  end

  for (genvar gi = 1; gi < NUM_FFS; gi++) begin : g_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_reg[gi] <= RST_VAL;
      end else begin
        stage_reg[gi] <= stage_reg[gi-1];
      end
    end
  end

  assign sync_val = stage_reg[NUM_FFS-1];

  // Filter state and edge outputs.
  logic [WIDTH-1:0] filt_reg;
  logic [WIDTH-1:0] filt_next;
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] fall_reg;
  logic             any_edge_reg;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          filt_bit_next;

    always_comb begin
      filt_bit_next = filt_reg[gi];
      cnt_next      = cnt_reg;
      if (bus.filt_bypass[gi]) begin
        // Bypass follows the synchroniser directly and discards any count.
        filt_bit_next = sync_val[gi];
        cnt_next      = '0;
      end else if (sync_val[gi] == filt_reg[gi]) begin
        // Any agreeing sample restarts the stability run.
        cnt_next = '0;
      end else if (cnt_reg == CNT_MAX) begin
        filt_bit_next = sync_val[gi];
        cnt_next      = '0;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_next;
      end
    end

    assign filt_next[gi] = filt_bit_next;
  end

  // Edges are computed from the next filter state so the pulses register
  // in the same cycle that filt_out shows the new level.
  assign rise_next = filt_next & ~filt_reg;
  assign fall_next = ~filt_next & filt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_reg     <= RST_VAL;
      rise_reg     <= '0;
      fall_reg     <= '0;
      any_edge_reg <= 1'b0;
    end else begin
      filt_reg     <= filt_next;
      rise_reg     <= rise_next;
      fall_reg     <= fall_next;
      any_edge_reg <= |(rise_next | fall_next);
    end
  end

  assign bus.sync_out = sync_val;
  assign bus.filt_out = filt_reg;
  assign bus.rise     = rise_reg;
  assign bus.fall     = fall_reg;
  assign bus.any_edge = any_edge_reg;

endmodule

// File: tb/tb_sync_filter.sv
// tb_sync_filter: directed self-checking bench for sync_filter.
// Two instances: u_dut with default parameters and u_dut_ones with
// RST_VAL = 4'b1111 for the reset-mid-count scenario.
module tb_sync_filter;

  logic clk;
  logic rst;
  logic rst2;

  int n_checks = 0;
  int n_errors = 0;

  sync_filter_if #(.WIDTH(4)) sf_if ();
  sync_filter_if #(.WIDTH(4)) sf_if2 ();

  sync_filter #(
    .WIDTH(4), .NUM_FFS(2), .FILT_CYCLES(4), .RST_VAL(4'b0000)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(sf_if)
  );

  sync_filter #(
    .WIDTH(4), .NUM_FFS(2), .FILT_CYCLES(4), .RST_VAL(4'b1111)
  ) u_dut_ones (
    .clk(clk),
    .rst(rst2),
    .bus(sf_if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive DUT1 inputs at the negedge, then sample 1 time unit after posedge.
  task automatic cyc(input logic [3:0] a);
    @(negedge clk);
    sf_if.async_in = a;
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    for (int k = 0; k < 12; k++) cyc(4'b0000);
    chk("settle_filt", 32'(sf_if.filt_out), 32'h0);
  endtask

  logic [6:0] chatter_pat;

  initial begin
    rst  = 1'b0;
    rst2 = 1'b0;
    sf_if.async_in     = '0;
    sf_if.filt_bypass  = '0;
    sf_if2.async_in    = '0;
    sf_if2.filt_bypass = '0;
    #2;
    rst  = 1'b1;
    rst2 = 1'b1;
    #1;
    chk("rst_sync",  32'(sf_if.sync_out), 32'h0);
    chk("rst_filt",  32'(sf_if.filt_out), 32'h0);
    chk("rst_rise",  32'(sf_if.rise), 32'h0);
    chk("rst_fall",  32'(sf_if.fall), 32'h0);
    chk("rst_any",   32'(sf_if.any_edge), 32'h0);
    chk("rst2_filt", 32'(sf_if2.filt_out), 32'hF);
    chk("rst2_sync", 32'(sf_if2.sync_out), 32'hF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic latency on ch0: rise.
    for (int k = 1; k <= 8; k++) begin
      cyc(4'b0001);
      $display("t1 k=%0d sync=%b filt=%b rise=%b", k, sf_if.sync_out, sf_if.filt_out, sf_if.rise);
      chk($sformatf("t1_sync k=%0d", k), 32'(sf_if.sync_out[0]), 32'(k >= 2));
      chk($sformatf("t1_filt k=%0d", k), 32'(sf_if.filt_out[0]), 32'(k >= 6));
      chk($sformatf("t1_rise k=%0d", k), 32'(sf_if.rise), (k == 6) ? 32'h1 : 32'h0);
      chk($sformatf("t1_any k=%0d", k), 32'(sf_if.any_edge), 32'(k == 6));
    end
    // Basic latency on ch0: fall.
    for (int k = 1; k <= 8; k++) begin
      cyc(4'b0000);
      $display("t1f k=%0d filt=%b fall=%b", k, sf_if.filt_out, sf_if.fall);
      chk($sformatf("t1f_filt k=%0d", k), 32'(sf_if.filt_out[0]), 32'(k < 6));
      chk($sformatf("t1f_fall k=%0d", k), 32'(sf_if.fall), (k == 6) ? 32'h1 : 32'h0);
      chk($sformatf("t1f_rise k=%0d", k), 32'(sf_if.rise), 32'h0);
    end

    // Glitch of 3 clocks on ch1 is rejected.
    for (int k = 1; k <= 12; k++) begin
      cyc((k <= 3) ? 4'b0010 : 4'b0000);
      $display("t2a k=%0d filt=%b rise=%b fall=%b", k, sf_if.filt_out, sf_if.rise, sf_if.fall);
      chk($sformatf("t2a_filt k=%0d", k), 32'(sf_if.filt_out), 32'h0);
      chk($sformatf("t2a_edge k=%0d", k), 32'(sf_if.rise | sf_if.fall), 32'h0);
    end
    // Pulse of 4 clocks on ch1 is accepted.
    for (int k = 1; k <= 14; k++) begin
      cyc((k <= 4) ? 4'b0010 : 4'b0000);
      $display("t2b k=%0d filt=%b rise=%b fall=%b", k, sf_if.filt_out, sf_if.rise, sf_if.fall);
      chk($sformatf("t2b_filt k=%0d", k), 32'(sf_if.filt_out), (k >= 6 && k < 10) ? 32'h2 : 32'h0);
      chk($sformatf("t2b_rise k=%0d", k), 32'(sf_if.rise), (k == 6) ? 32'h2 : 32'h0);
      chk($sformatf("t2b_fall k=%0d", k), 32'(sf_if.fall), (k == 10) ? 32'h2 : 32'h0);
    end

    // Chatter on ch2: 1,1,0,1,1,1,1 then held high.
    chatter_pat = 7'b1111011; // bit index k-1 is the sample for cycle k
    for (int k = 1; k <= 12; k++) begin
      logic b;
      b = (k <= 7) ? chatter_pat[k-1] : 1'b1;
      cyc({1'b0, b, 2'b00});
      $display("t3 k=%0d in=%b filt=%b rise=%b", k, b, sf_if.filt_out, sf_if.rise);
      chk($sformatf("t3_filt k=%0d", k), 32'(sf_if.filt_out), (k >= 9) ? 32'h4 : 32'h0);
      chk($sformatf("t3_rise k=%0d", k), 32'(sf_if.rise), (k == 9) ? 32'h4 : 32'h0);
    end
    settle();

    // Simultaneous rise on ch0 and ch3.
    for (int k = 1; k <= 8; k++) begin
      cyc(4'b1001);
      $display("t4 k=%0d filt=%b rise=%b any=%b", k, sf_if.filt_out, sf_if.rise, sf_if.any_edge);
      chk($sformatf("t4_filt k=%0d", k), 32'(sf_if.filt_out), (k >= 6) ? 32'h9 : 32'h0);
      chk($sformatf("t4_rise k=%0d", k), 32'(sf_if.rise), (k == 6) ? 32'h9 : 32'h0);
      chk($sformatf("t4_any k=%0d", k), 32'(sf_if.any_edge), 32'(k == 6));
    end
    settle();

    // Bypass on ch2 with a single-cycle input pulse.
    sf_if.filt_bypass = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      cyc((k == 1) ? 4'b0100 : 4'b0000);
      $display("t5 k=%0d sync=%b filt=%b rise=%b fall=%b", k, sf_if.sync_out, sf_if.filt_out, sf_if.rise, sf_if.fall);
      chk($sformatf("t5_sync k=%0d", k), 32'(sf_if.sync_out), (k == 2) ? 32'h4 : 32'h0);
      chk($sformatf("t5_filt k=%0d", k), 32'(sf_if.filt_out), (k == 3) ? 32'h4 : 32'h0);
      chk($sformatf("t5_rise k=%0d", k), 32'(sf_if.rise), (k == 3) ? 32'h4 : 32'h0);
      chk($sformatf("t5_fall k=%0d", k), 32'(sf_if.fall), (k == 4) ? 32'h4 : 32'h0);
      chk($sformatf("t5_any k=%0d", k), 32'(sf_if.any_edge), 32'(k == 3 || k == 4));
    end
    sf_if.filt_bypass = 4'b0000;
    settle();

    // RST_VAL=1111 instance: reset asserted two counts into a 1->0 filter.
    @(negedge clk);
    rst2 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      $display("t6a k=%0d filt=%b fall=%b", k, sf_if2.filt_out, sf_if2.fall);
      chk($sformatf("t6a_filt k=%0d", k), 32'(sf_if2.filt_out), 32'hF);
      chk($sformatf("t6a_fall k=%0d", k), 32'(sf_if2.fall), 32'h0);
    end
    #2;
    rst2 = 1'b1;
    #1;
    $display("t6b async rst filt=%b sync=%b fall=%b", sf_if2.filt_out, sf_if2.sync_out, sf_if2.fall);
    chk("t6b_filt", 32'(sf_if2.filt_out), 32'hF);
    chk("t6b_sync", 32'(sf_if2.sync_out), 32'hF);
    chk("t6b_fall", 32'(sf_if2.fall), 32'h0);
    chk("t6b_any",  32'(sf_if2.any_edge), 32'h0);
    @(negedge clk);
    rst2 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      $display("t6c k=%0d filt=%b fall=%b any=%b", k, sf_if2.filt_out, sf_if2.fall, sf_if2.any_edge);
      chk($sformatf("t6c_filt k=%0d", k), 32'(sf_if2.filt_out), (k < 6) ? 32'hF : 32'h0);
      chk($sformatf("t6c_fall k=%0d", k), 32'(sf_if2.fall), (k == 6) ? 32'hF : 32'h0);
      chk($sformatf("t6c_rise k=%0d", k), 32'(sf_if2.rise), 32'h0);
      chk($sformatf("t6c_any k=%0d", k), 32'(sf_if2.any_edge), 32'(k == 6));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_filter.md
# sync_filter

Multi-channel clock-domain-crossing front end for asynchronous level inputs such as buttons, straps and status lines from other clock domains. Each channel runs through a parametrised flip-flop synchroniser, then a stability (debounce) filter, then an edge detector. The block sits between the pads or foreign-domain signals and the control logic in the `clk` domain. It replaces the single-bit synchroniser where glitch rejection, multiple channels or edge pulses are needed.

## Interface
- `WIDTH`, 4: number of independent channels (≥1).
- `NUM_FFS`, 2: synchroniser depth per channel (≥2).
- `FILT_CYCLES`, 4: number of consecutive differing samples required to accept a new level (≥1). Counter width is `$clog2(FILT_CYCLES+1)`.
- `RST_VAL`, {WIDTH{1'b0}}: per-channel reset level of every synchroniser stage and of `filt_out`.

Ports:
- `clk`  input  1: sole clock. All logic is posedge.
- `rst`  input  1: asynchronous, active-high reset.
- `async_in`  input  WIDTH: asynchronous inputs, one per channel.
- `filt_bypass`  input  WIDTH: per-channel filter bypass. This input must be synchronous to `clk`.
- `sync_out`  output  WIDTH: last synchroniser stage (raw synchronised level).
- `filt_out`  output  WIDTH: filtered, stable level.
- `rise`  output  WIDTH: one-cycle pulse on a 0→1 change of `filt_out`.
- `fall`  output  WIDTH: one-cycle pulse on a 1→0 change of `filt_out`.
- `any_edge`  output  1: registered OR of the next-state `rise|fall` across all channels. It is coincident with those pulses.

## Operation
- Reset (async assert; release is synchronous in effect):
  - All `NUM_FFS` stages and `filt_out` take `RST_VAL`.
  - Counters clear to 0.
  - `rise`, `fall` and `any_edge` are 0.
  - No edge pulse is generated by reset or by reset release.
- Synchroniser: a plain shift chain, `stage[0] <= async_in`, `stage[k] <= stage[k-1]`. `sync_out = stage[NUM_FFS-1]`. There is no logic between stages.
- Filter, per channel, each posedge:
  - `sync_out == filt_out`: the counter is set to 0.
  - `sync_out != filt_out` and `cnt == FILT_CYCLES-1`: `filt_out <= sync_out` and the counter is set to 0.
  - Otherwise: `cnt <= cnt + 1`.
  - A run of differing samples shorter than `FILT_CYCLES` leaves `filt_out` unchanged, and the counter restarts from 0 after any agreeing sample.
  - The counter never exceeds `FILT_CYCLES-1`, so no wrap is possible.
- Bypass (`filt_bypass[i]=1`):
  - `filt_out[i] <= sync_out[i]` every cycle; the counter is held at 0.
  - Edge pulses are still produced.
  - Toggling bypass mid-count:
    - Bypass 1 discards the count.
    - Bypass 0 starts counting from 0.
- Edges:
  - `rise[i]`/`fall[i]` are registered and assert in the same cycle that `filt_out[i]` shows the new value, for exactly one cycle.
  - Back-to-back changes on consecutive cycles are only possible in bypass; they produce consecutive pulses of alternating type.
- Channels are fully independent. Simultaneous events on multiple channels each pulse their own bit; `any_edge` is 1 for that cycle.

## Timing
- `async_in` stable before posedge P1: `sync_out` changes after posedge P(NUM_FFS).
- `filt_out` and the edge pulse change after posedge P(NUM_FFS+FILT_CYCLES), provided the input stays stable.
  - Default latency is 6 cycles.
  - In bypass, latency is `NUM_FFS+1` cycles.
- Minimum accepted pulse width at `sync_out`: `FILT_CYCLES` cycles. Pulses of `FILT_CYCLES-1` cycles or fewer are rejected.
- Reset asserted mid-count: outputs take reset values immediately and asynchronously, with no pulse. After release, a still-differing input requires the full `NUM_FFS+FILT_CYCLES` latency again.

## Test plan
- Defaults, ch0 `async_in` 0→1 at negedge:
  - `sync_out[0]`=1 after 2 posedges.
  - `filt_out[0]`=1 and `rise[0]`=1 for exactly one cycle after 6 posedges.
  - Return to 0 gives `fall[0]` after 6 posedges.
- Glitch rejection: ch1 high for 3 clocks (negedge to negedge) → `filt_out[1]` stays 0, no `rise`/`fall`. Repeat with 4 clocks → exactly one `rise[1]` followed by one `fall[1]`.
- Interleaved chatter: ch2 toggles 1,1,0,1,1,1,1 per clock → counter restarts at the 0 sample; `rise[2]` appears 4 cycles after the final run begins, at the sync output.
- Simultaneous: ch0 and ch3 rise on the same negedge → `rise[0]`, `rise[3]` and `any_edge` coincide in one cycle; ch1 and ch2 are unaffected.
- Bypass: `filt_bypass[2]`=1, 1-cycle pulse on `async_in[2]` → `filt_out[2]` pulses 1 cycle after `sync_out[2]`, with `rise[2]` and `fall[2]` on consecutive cycles.
- Reset mid-count and `RST_VAL`=4'b1111:
  - `rst` asserted 2 cycles into a 1→0 filter → `filt_out`=4'b1111 immediately, no `fall`.
  - After release with inputs still 0 → `fall` appears on all channels exactly 6 cycles later.
